// File: rtl/ttl_74259_sync.sv
// Synchronous 74259 addressable latch / 1-of-N demultiplexer; Q is registered on Clk.
// Optional macro TTL_74259_TRANSPARENT_EN adds the real chip's transparent bypass onto Q.
module ttl_74259_sync #(
    parameter int                     OUTPUTS      = 8,
    parameter int                     WIDTH_SELECT = $clog2(OUTPUTS),
    parameter logic [OUTPUTS-1:0]     RESET_VALUE  = {OUTPUTS{1'b0}}
) (
    input  logic                    Clk,
    input  logic                    Reset_bar,
    input  logic                    Clear_bar,
    input  logic                    Enable_bar,
    input  logic [WIDTH_SELECT-1:0] Address,
    input  logic                    D,
    output logic [OUTPUTS-1:0]      Q
);

    typedef enum logic [1:0] {
        MODE_CLEAR  = 2'b01,
        MODE_DEMUX  = 2'b00,
        MODE_LATCH  = 2'b10,
        MODE_MEMORY = 2'b11
    } mode_t;

    logic [OUTPUTS-1:0] q_reg;
    logic [OUTPUTS-1:0] next_q;
    mode_t              mode;

    assign mode = mode_t'({Clear_bar, Enable_bar});

    // The mode table applied to the current inputs; feeds both the register and the bypass.
    always_comb begin
        next_q = q_reg;
        case (mode)
            MODE_LATCH:  next_q[Address] = D;
            MODE_MEMORY: next_q = q_reg;
            MODE_DEMUX: begin
                next_q          = '0;
                next_q[Address] = D;
            end
            MODE_CLEAR:  next_q = '0;
            default:     next_q = q_reg;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_bar) begin
            q_reg <= RESET_VALUE;
        end else begin
            q_reg <= next_q;
        end
    end

`ifdef TTL_74259_TRANSPARENT_EN
    // In memory mode next_q equals q_reg, so Q stays continuous when enable deasserts.
    assign Q = Reset_bar ? next_q : RESET_VALUE;
`else
    assign Q = q_reg;
`endif

endmodule

// File: tb/tb_ttl_74259_sync.sv
// Self-checking bench for ttl_74259_sync: directed scenarios plus random stimulus
// compared against a behavioural model of the mode table.
module tb_ttl_74259_sync;

    logic       Clk = 1'b0;
    logic       Reset_bar = 1'b0;
    logic       Clear_bar = 1'b1;
    logic       Enable_bar = 1'b1;
    logic [2:0] Address = '0;
    logic       D = 1'b0;
    logic [7:0] Q;

    int total = 0;
    int bad = 0;
    logic [7:0] model_q = 8'h00;

    ttl_74259_sync #(.OUTPUTS(8)) dut (
        .Clk(Clk),
        .Reset_bar(Reset_bar),
        .Clear_bar(Clear_bar),
        .Enable_bar(Enable_bar),
        .Address(Address),
        .D(D),
        .Q(Q)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        bad = bad + 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Reference: what the eight control bits become after one edge with these pins.
    function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic rb, input logic cb,
                                            input logic eb, input logic [2:0] a, input logic d);
        int bitval;
        bitval = 1 << a;
        if (!rb) return 8'h00;
        if (cb && !eb) return d ? (cur | 8'(bitval)) : (cur & ~8'(bitval));
        if (cb && eb) return cur;
        if (!cb && !eb) return d ? 8'(bitval) : 8'h00;
        return 8'h00;
    endfunction

    // What Q should read right now, given the model register and current pins.
    function automatic logic [7:0] exp_q();
`ifdef TTL_74259_TRANSPARENT_EN
        return ref_next(model_q, Reset_bar, Clear_bar, Enable_bar, Address, D);
`else
        return model_q;
`endif
    endfunction

    task automatic drive(input logic rb, input logic cb, input logic eb,
                         input logic [2:0] a, input logic d);
        @(negedge Clk);
        Reset_bar  = rb;
        Clear_bar  = cb;
        Enable_bar = eb;
        Address    = a;
        D          = d;
        @(posedge Clk);
        model_q = ref_next(model_q, rb, cb, eb, a, d);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 3'd3, 1'b1);
            total = total + 1;
            if (Q !== 8'h00) begin
                bad = bad + 1;
                $display("FAIL reset_hold[%0d]: got %h want 00", i, Q);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 3'd3, 1'b1);
        total = total + 1;
        if (Q !== 8'h08) begin
            bad = bad + 1;
            $display("FAIL reset_release: got %h want 08", Q);
        end
        drive(1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
    endtask

    task automatic test_latch();
        logic [2:0] addrs [3] = '{3'd0, 3'd2, 3'd7};
        logic [7:0] wants [3] = '{8'h01, 8'h05, 8'h85};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, addrs[i], 1'b1);
            total = total + 1;
            if (Q !== wants[i]) begin
                bad = bad + 1;
                $display("FAIL latch_write[%0d]: got %h want %h", i, Q, wants[i]);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
        total = total + 1;
        if (Q !== 8'h81) begin
            bad = bad + 1;
            $display("FAIL latch_clear_bit: got %h want 81", Q);
        end
    endtask

    task automatic test_memory();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            total = total + 1;
            if (Q !== 8'h81) begin
                bad = bad + 1;
                $display("FAIL memory_hold[%0d]: got %h want 81", i, Q);
            end
        end
    endtask

    task automatic test_demux();
        drive(1'b1, 1'b0, 1'b0, 3'd5, 1'b1);
        total = total + 1;
        if (Q !== 8'h20) begin
            bad = bad + 1;
            $display("FAIL demux_d1: got %h want 20", Q);
        end
        drive(1'b1, 1'b0, 1'b0, 3'd5, 1'b0);
        total = total + 1;
        if (Q !== 8'h00) begin
            bad = bad + 1;
            $display("FAIL demux_d0: got %h want 00", Q);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 3'(i), 1'b1);
        total = total + 1;
        if (Q !== 8'hFF) begin
            bad = bad + 1;
            $display("FAIL clear_setup: got %h want ff", Q);
        end
        drive(1'b1, 1'b0, 1'b1, 3'd4, 1'b1);
        total = total + 1;
        if (Q !== 8'h00) begin
            bad = bad + 1;
            $display("FAIL clear_all: got %h want 00", Q);
        end
        drive(1'b1, 1'b1, 1'b0, 3'd1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 3'd6, 1'b1);
        total = total + 1;
        if (Q !== 8'h00) begin
            bad = bad + 1;
            $display("FAIL reset_with_clear: got %h want 00", Q);
        end
    endtask

    task automatic test_back_to_back();
        logic d;
        drive(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            d = 1'($urandom_range(0, 1));
            drive(1'b1, 1'b1, 1'b0, 3'd6, d);
            total = total + 1;
            if (Q[6] !== d || Q !== exp_q()) begin
                bad = bad + 1;
                $display("FAIL back_to_back[%0d]: got %h want %h", i, Q, exp_q());
            end
        end
    endtask

    task automatic test_random();
        logic rb;
        for (int i = 0; i < 300; i++) begin
            rb = ($urandom_range(0, 19) != 0);
            drive(rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            total = total + 1;
            if (Q !== exp_q()) begin
                bad = bad + 1;
                $display("FAIL random[%0d]: got %h want %h", i, Q, exp_q());
            end
        end
    endtask

`ifdef TTL_74259_TRANSPARENT_EN
    task automatic test_transparent();
        @(negedge Clk);
        Reset_bar = 1'b1; Clear_bar = 1'b1; Enable_bar = 1'b0; Address = 3'd4; D = 1'b1;
        #1;
        total = total + 1;
        if (Q[4] !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL transparent_d1: got %b want 1", Q[4]);
        end
        D = 1'b0;
        #1;
        total = total + 1;
        if (Q[4] !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL transparent_d0: got %b want 0", Q[4]);
        end
        D = 1'b1;
        @(posedge Clk);
        model_q = ref_next(model_q, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1);
        #1;
        Enable_bar = 1'b1;
        D = 1'b0;
        #1;
        total = total + 1;
        if (Q[4] !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL transparent_hold: got %b want 1", Q[4]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latch();
        test_memory();
        test_demux();
        test_clear();
        test_back_to_back();
        test_random();
`ifdef TTL_74259_TRANSPARENT_EN
        test_transparent();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
